rr_multi_chan_fifo: RTL
=======================

Name: rr_multi_chan_fifo

Overview:
- Parametrised N-channel ingress buffer.
- Arbitrates NUM_CH valid/ready input channels round-robin into one shared synchronous FIFO.
- Presents a single valid/ready output stream; each word is tagged with its source channel.
- Generalises the team's single-port fixed-width port blocks to configurable data width, channel count and depth.

Parameters:
- DATA_W, 8: data bits per channel word.
- NUM_CH, 4: number of input channels, >=2.
- DEPTH, 8: FIFO entries; power of two, >=2.
- CH_W (localparam): $clog2(NUM_CH), channel tag width.
- CNT_W (localparam): $clog2(DEPTH)+1, fill counter width.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  NUM_CH  per-channel word valid.
- in_data  input  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- in_ready  output  NUM_CH  per-channel accept.
- out_valid  output  1  head word valid.
- out_data  output  DATA_W  head word.
- out_ch  output  CH_W  source channel of head word.
- out_ready  input  1  consumer accept.
- fill_level  output  CNT_W  stored entries, 0..DEPTH.
- full  output  1  fill_level==DEPTH.
- empty  output  1  fill_level==0.

Behaviour:
- Reset (async assert, sync deassert handled upstream): wr_ptr=0, rd_ptr=0, fill_level=0, last_grant=NUM_CH-1. Outputs: out_valid=0, full=0, empty=1, in_ready=all 0. Storage array is not cleared. out_data/out_ch are don't-care while out_valid=0.
- Arbitration (combinational):
  - grant = first requesting channel scanning last_grant+1, last_grant+2, ..., wrapping modulo NUM_CH.
  - At most one grant per cycle.
  - in_ready[i] = grant[i] & !full & rst_n.
- Push: in_valid[g] & in_ready[g] at a clock edge writes {g, in_data[g]} at wr_ptr. wr_ptr increments, wrapping DEPTH-1 -> 0. last_grant <= g.
  - last_grant updates only on an accepted push. A grant without a push (full) leaves priority unchanged.
- Pop: out_valid & out_ready at the edge. rd_ptr increments with wrap.
- Output: first-word fall-through from a registered array.
  - out_valid = !empty.
  - Push-to-out_valid latency = 1 cycle. No same-cycle bypass when empty.
- Counter:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
  - Never exceeds DEPTH, never underflows.
- Full: in_ready all 0, even if a pop occurs the same cycle. A freed slot becomes usable the next cycle. No ready pass-through.
- Empty: out_valid=0. out_ready is ignored.
- Stability: while out_valid & !out_ready, out_data and out_ch hold.
- Upstream rule: a channel holds valid and data until accepted. The block does not check this.
- Throughput: one push and one pop per cycle sustained when neither full nor empty.
- Fairness: with all channels continuously requesting and the FIFO never full, the grant sequence is 0,1,...,NUM_CH-1,0,...
- Reset mid-operation: all stored words are discarded; the next word out is the first word pushed after reset.

Test Plan:
- Reset, then ch2 alone pushes 0xA5 at cycle 0 -> in_ready=4'b0100; out_valid=1, out_data=0xA5, out_ch=2, fill_level=1 at cycle 1.
- All 4 channels valid continuously, out_ready=1 -> accepted order ch0,ch1,ch2,ch3,ch0; fill_level steady at 1; output tags 0,1,2,3,0.
- out_ready=0, ch1 pushes 0x10..0x17 -> after 8 pushes full=1, fill_level=8, in_ready=0. Next out_ready=1 cycle -> pop 0x10, in_ready still 0 that cycle, in_ready[1]=1 the cycle after.
- Fill to 8, then 20 cycles of simultaneous push and pop after one pop -> wr_ptr/rd_ptr wrap correctly; data emerges in push order with no loss or duplication; fill_level never exceeds 8.
- Requests only on ch3 and ch0, last_grant=3 -> ch0 granted, then ch3 (grant skips idle ch1 and ch2).
- Fill 5 words, assert rst_n=0 mid-cycle -> out_valid=0, empty=1, fill_level=0 immediately. After release, push 0x3C on ch1 -> first output is 0x3C, out_ch=1.

Source files
------------

// File: rtl/rr_multi_chan_fifo.sv
// ---------------------------------------------------------------------------
// rr_multi_chan_fifo
//
// Parametrised N-channel ingress buffer. NUM_CH valid/ready input channels
// are arbitrated round-robin into one shared synchronous FIFO, and the FIFO
// drains through a single first-word-fall-through valid/ready stream. Every
// stored word carries the index of the channel it came from.
//
// Ports:
//   clk           single clock, rising edge
//   rst_n         asynchronous active-low reset
//   in_valid_i    per-channel word valid                  [NUM_CH]
//   in_data_i     channel i in bits [i*DATA_W +: DATA_W]   [NUM_CH*DATA_W]
//   in_ready_o    per-channel accept                      [NUM_CH]
//   out_valid_o   head word valid
//   out_data_o    head word                               [DATA_W]
//   out_ch_o      source channel of head word             [CH_W]
//   out_ready_i   consumer accept
//   fill_level_o  stored entries, 0..DEPTH                [CNT_W]
//   full_o        fill_level_o == DEPTH
//   empty_o       fill_level_o == 0
// ---------------------------------------------------------------------------
module rr_multi_chan_fifo #(
  parameter  int DATA_W = 8,
  parameter  int NUM_CH = 4,
  parameter  int DEPTH  = 8,
  localparam int CH_W   = $clog2(NUM_CH),
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_valid_i,
  input  logic [NUM_CH*DATA_W-1:0] in_data_i,
  output logic [NUM_CH-1:0]        in_ready_o,
  output logic                     out_valid_o,
  output logic [DATA_W-1:0]        out_data_o,
  output logic [CH_W-1:0]          out_ch_o,
  input  logic                     out_ready_i,
  output logic [CNT_W-1:0]         fill_level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = CH_W + DATA_W;

  // Storage is deliberately left out of reset; only the pointers and the
  // fill counter define which entries are meaningful.
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]  fillLevel_q, fillLevel_d;
  logic [CH_W-1:0]   lastGrant_q, lastGrant_d;

  logic [NUM_CH-1:0] grantVec;
  logic [CH_W-1:0]   grantIdx;
  logic [DATA_W-1:0] grantData;
  logic              grantAny;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  assign full  = (fillLevel_q == CNT_W'(DEPTH));
  assign empty = (fillLevel_q == '0);

  // Round-robin scan: start one past the last channel that actually pushed
  // and take the first requester found, wrapping modulo NUM_CH.
  always_comb begin
    logic [CH_W-1:0] cand;
    grantVec  = '0;
    grantIdx  = '0;
    grantData = '0;
    grantAny  = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = CH_W'((int'(lastGrant_q) + k) % NUM_CH);
      if (!grantAny && in_valid_i[cand]) begin
        grantAny       = 1'b1;
        grantIdx       = cand;
        grantVec[cand] = 1'b1;
        grantData      = in_data_i[cand*DATA_W +: DATA_W];
      end
    end
  end

  // Ready is gated by the registered full flag only, so a pop in the same
  // cycle never opens a slot early; rst_n keeps every channel stalled while
  // the block is held in reset.
  assign in_ready_o = grantVec & {NUM_CH{(!full) && rst_n}};

  assign push = grantAny && !full && rst_n;
  assign pop  = !empty && out_ready_i;

  // Next-state for pointers, fill counter and arbitration priority.
  // Priority moves only when a word is really accepted.
  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    fillLevel_d = fillLevel_q;
    lastGrant_d = lastGrant_q;
    if (push) begin
      wrPtr_d     = wrPtr_q + PTR_W'(1);
      lastGrant_d = grantIdx;
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   fillLevel_d = fillLevel_q + CNT_W'(1);
      2'b01:   fillLevel_d = fillLevel_q - CNT_W'(1);
      default: fillLevel_d = fillLevel_q;
    endcase
  end

  // Control state register; pointers wrap naturally because DEPTH is a
  // power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      fillLevel_q <= '0;
      lastGrant_q <= CH_W'(NUM_CH - 1);
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      fillLevel_q <= fillLevel_d;
      lastGrant_q <= lastGrant_d;
    end
  end

  // Storage write: the source tag is stored alongside the data word.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= {grantIdx, grantData};
    end
  end

  // First-word fall-through: the head entry is read straight out of the
  // registered array, so a freshly pushed word appears one cycle later.
  assign {out_ch_o, out_data_o} = mem_q[rdPtr_q];
  assign out_valid_o            = !empty;
  assign fill_level_o           = fillLevel_q;
  assign full_o                 = full;
  assign empty_o                = empty;

endmodule
